// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   hz_state_t : controller FSM states
//   hz_ctrl_t  : bundle of the five pipeline control outputs
//   max_u      : elaboration-time helper for sizing the sequence counter
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_LOAD_STALL,
    HZ_FLUSH
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic ctrl_mux_sel;
    logic if_flush;
    logic pipe_freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, if_id_write: 1'b1, ctrl_mux_sel: 1'b0, if_flush: 1'b0, pipe_freeze: 1'b0};
  localparam hz_ctrl_t CTRL_STALL = '{
    pc_write: 1'b0, if_id_write: 1'b0, ctrl_mux_sel: 1'b1, if_flush: 1'b0, pipe_freeze: 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH = '{
    pc_write: 1'b1, if_id_write: 1'b1, ctrl_mux_sel: 1'b1, if_flush: 1'b1, pipe_freeze: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, if_id_write: 1'b0, ctrl_mux_sel: 1'b0, if_flush: 1'b0, pipe_freeze: 1'b1};
  // Safe values while reset is held: nothing advances, IF/ID is squashed, ID/EX is a bubble.
  localparam hz_ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, if_id_write: 1'b0, ctrl_mux_sel: 1'b1, if_flush: 1'b1, pipe_freeze: 1'b0};

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bus: ID/EX observation inputs, memory status, counter clear,
// and the pipeline control / performance-counter outputs.
//   master : pipeline side (drives *_i, observes *_o)
//   slave  : hazard controller (observes *_i, drives *_o)
interface hazard_ctrl_unit_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
) ();

  logic [NUM_SRC*REG_AW-1:0] id_rs_i;
  logic [NUM_SRC-1:0]        id_rs_valid_i;
  logic                      id_mem_write_i;
  logic [REG_AW-1:0]         ex_rd_i;
  logic                      ex_mem_read_i;
  logic                      branch_taken_i;
  logic                      mem_busy_i;
  logic                      cnt_clr_i;
  logic                      pc_write_o;
  logic                      if_id_write_o;
  logic                      ctrl_mux_sel_o;
  logic                      if_flush_o;
  logic                      pipe_freeze_o;
  logic [CNT_W-1:0]          stall_cycles_o;
  logic [CNT_W-1:0]          flush_events_o;

  modport master (
    output id_rs_i, id_rs_valid_i, id_mem_write_i, ex_rd_i, ex_mem_read_i,
    output branch_taken_i, mem_busy_i, cnt_clr_i,
    input  pc_write_o, if_id_write_o, ctrl_mux_sel_o, if_flush_o, pipe_freeze_o,
    input  stall_cycles_o, flush_events_o
  );

  modport slave (
    input  id_rs_i, id_rs_valid_i, id_mem_write_i, ex_rd_i, ex_mem_read_i,
    input  branch_taken_i, mem_busy_i, cnt_clr_i,
    output pc_write_o, if_id_write_o, ctrl_mux_sel_o, if_flush_o, pipe_freeze_o,
    output stall_cycles_o, flush_events_o
  );

endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   inc_i    : add one this cycle (ignored once at all-ones)
//   clr_i    : synchronous clear, wins over inc_i
//   count_o  : current count
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller between IF/ID and ID/EX of the in-order pipeline.
// Detects load-use hazards over NUM_SRC operands, sequences multi-cycle load stalls
// and wrong-path flushes, freezes the back end while data memory is busy, and keeps
// saturating counts of stall cycles and flush events.
//   clk, rst : clock, asynchronous active-high reset
//   hz_bus   : hazard_ctrl_unit_if slave (ID/EX observation in, pipeline controls out)
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned LOAD_LAT       = 1,
  parameter int unsigned FLUSH_DEPTH    = 1,
  parameter int unsigned STORE_FWD      = 1,
  parameter int unsigned STORE_DATA_IDX = 1,
  parameter int unsigned CNT_W          = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_ctrl_unit_if.slave hz_bus
);

  localparam int unsigned SEQ_MAX = max_u(LOAD_LAT, FLUSH_DEPTH);
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] LOAD_RELOAD  = SEQ_W'(LOAD_LAT - 1);
  localparam logic [SEQ_W-1:0] FLUSH_RELOAD = SEQ_W'(FLUSH_DEPTH - 1);

  hz_state_t        state_q;
  logic [SEQ_W-1:0] cnt_q;
  logic             load_use;
  hz_ctrl_t         ctrl;
  logic             stall_inc;
  logic             flush_inc;

  always_comb begin
    load_use = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      // MEM-stage forwarding supplies store data, so that operand never needs a stall.
      if (hz_bus.id_rs_valid_i[i] && hz_bus.ex_mem_read_i && (hz_bus.ex_rd_i != '0) &&
          (hz_bus.ex_rd_i == hz_bus.id_rs_i[i*REG_AW +: REG_AW]) &&
          !((STORE_FWD != 0) && hz_bus.id_mem_write_i && (i == STORE_DATA_IDX))) begin
        load_use = 1'b1;
      end
    end
  end

  // Outputs react in the same cycle as the hazard; the FSM only tracks the tail.
  always_comb begin
    ctrl      = CTRL_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (hz_bus.mem_busy_i) begin
      ctrl = CTRL_FREEZE;
    end else if (hz_bus.branch_taken_i) begin
      ctrl      = CTRL_FLUSH;
      flush_inc = 1'b1;
    end else begin
      unique case (state_q)
        HZ_FLUSH: ctrl = CTRL_FLUSH;
        HZ_LOAD_STALL: begin
          ctrl      = CTRL_STALL;
          stall_inc = 1'b1;
        end
        default: begin
          if (load_use) begin
            ctrl      = CTRL_STALL;
            stall_inc = 1'b1;
          end
        end
      endcase
    end
  end

  // cnt_q holds the number of sequence cycles still owed after the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else if (!hz_bus.mem_busy_i) begin
      if (hz_bus.branch_taken_i) begin
        state_q <= (FLUSH_DEPTH > 1) ? HZ_FLUSH : HZ_RUN;
        cnt_q   <= FLUSH_RELOAD;
      end else begin
        unique case (state_q)
          HZ_FLUSH, HZ_LOAD_STALL: begin
            if (cnt_q <= SEQ_W'(1)) begin
              state_q <= HZ_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - SEQ_W'(1);
            end
          end
          HZ_RUN: begin
            if (load_use && (LOAD_LAT > 1)) begin
              state_q <= HZ_LOAD_STALL;
              cnt_q   <= LOAD_RELOAD;
            end
          end
          default: begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign hz_bus.pc_write_o     = ctrl.pc_write;
  assign hz_bus.if_id_write_o  = ctrl.if_id_write;
  assign hz_bus.ctrl_mux_sel_o = ctrl.ctrl_mux_sel;
  assign hz_bus.if_flush_o     = ctrl.if_flush;
  assign hz_bus.pipe_freeze_o  = ctrl.pipe_freeze;

  hazard_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (stall_inc),
    .clr_i  (hz_bus.cnt_clr_i),
    .count_o(hz_bus.stall_cycles_o)
  );

  hazard_sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (flush_inc),
    .clr_i  (hz_bus.cnt_clr_i),
    .count_o(hz_bus.flush_events_o)
  );

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised, stateful hazard controller for the in-order RISC-V pipeline, sitting between the IF/ID and ID/EX stages. It generates PC/IF-ID write enables, control-bubble select and IF flush. It generalises load-use detection to N source operands with a configurable multi-cycle load latency. It adds multi-cycle wrong-path flush, a data-memory busy freeze and saturating performance counters.

## Interface
- REG_AW, 5: register address width.
- NUM_SRC, 2: source operands checked in ID.
- LOAD_LAT, 1: stall cycles per load-use hazard (≥1).
- FLUSH_DEPTH, 1: cycles if_flush is held after a taken branch (≥1).
- STORE_FWD, 1: if 1, the store-data operand is exempt from load-use stall (MEM-stage forwarding covers it).
- STORE_DATA_IDX, 1: source index carrying store data.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_rs_i  in  NUM_SRC*REG_AW  ID source register addresses; source i occupies bits [i*REG_AW +: REG_AW].
- id_rs_valid_i  in  NUM_SRC  source i is actually read.
- id_mem_write_i  in  1  ID instruction is a store.
- ex_rd_i  in  REG_AW  EX destination register.
- ex_mem_read_i  in  1  EX instruction is a load.
- branch_taken_i  in  1  EX branch resolved taken.
- mem_busy_i  in  1  data memory not ready.
- cnt_clr_i  in  1  synchronous clear of the performance counters.
- pc_write_o  out  1  PC update enable.
- if_id_write_o  out  1  IF/ID register enable.
- ctrl_mux_sel_o  out  1  zero ID/EX control (bubble).
- if_flush_o  out  1  squash IF/ID contents.
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB.
- stall_cycles_o  out  CNT_W  saturating count of load-use stall cycles.
- flush_events_o  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- hz(i) = id_rs_valid_i[i] & ex_mem_read_i & (ex_rd_i≠0) & (ex_rd_i==rs[i]) & !(STORE_FWD & id_mem_write_i & i==STORE_DATA_IDX). load_use = OR over i.
- FSM states: HZ_RUN, HZ_LOAD_STALL, HZ_FLUSH. Down-counter cnt, width $clog2(max(LOAD_LAT,FLUSH_DEPTH)+1).
- Priority in every state: mem_busy_i > branch_taken_i > load stall > run.
- Freeze (mem_busy_i=1): pipe_freeze_o=1, pc_write_o=0, if_id_write_o=0, ctrl_mux_sel_o=0, if_flush_o=0. State, cnt and counters hold. branch_taken_i is ignored and is re-sampled once busy drops.
- Flush: entered on branch_taken_i in any state, including aborting an active LOAD_STALL. Each flush cycle drives if_flush_o=1, ctrl_mux_sel_o=1, pc_write_o=1, if_id_write_o=1.
  - The taken cycle is flush cycle 1. If FLUSH_DEPTH>1, go to HZ_FLUSH with cnt=FLUSH_DEPTH-1, then decrement to 0 and return to HZ_RUN.
  - flush_events_o increments once per entry.
  - A new branch_taken_i inside HZ_FLUSH reloads cnt and increments again.
- Load stall: in HZ_RUN, load_use gives a stall cycle: pc_write_o=0, if_id_write_o=0, ctrl_mux_sel_o=1, if_flush_o=0.
  - If LOAD_LAT>1, go to HZ_LOAD_STALL with cnt=LOAD_LAT-1.
  - HZ_LOAD_STALL holds the same outputs regardless of load_use, because EX holds a bubble. It decrements and returns to HZ_RUN after cnt reaches 0.
  - stall_cycles_o increments each stall cycle.
- Run: pc_write_o=1, if_id_write_o=1, others 0.
- Counters saturate at 2^CNT_W-1. cnt_clr_i wins over a same-cycle increment.

## Timing
- Outputs are combinational from inputs and the registered state. There is zero-cycle latency from hazard detection to stall or flush.
- Load-use stall lasts exactly LOAD_LAT non-frozen cycles. Flush lasts exactly FLUSH_DEPTH non-frozen cycles. Freeze cycles extend both without consuming cnt.
- Reset asserted, asynchronously:
  - State is HZ_RUN, cnt=0, counters=0.
  - Outputs are forced to pc_write_o=0, if_id_write_o=0, ctrl_mux_sel_o=1, if_flush_o=1, pipe_freeze_o=0.
  - Reset mid-stall or mid-flush abandons the sequence.
  - First cycle after deassertion evaluates as HZ_RUN.

## Structure
- hazard_pkg holds hz_state_t {HZ_RUN, HZ_LOAD_STALL, HZ_FLUSH} and the output-bundle struct hz_ctrl_t {pc_write, if_id_write, ctrl_mux_sel, if_flush, pipe_freeze}.
- Sub-module hazard_sat_counter (CNT_W, inc, clr): instantiated twice for the performance counters.

## Test plan
- LOAD_LAT=2: ex_mem_read_i=1, ex_rd_i=5, id_rs_i source0=5 → exactly 2 cycles of pc_write_o=0 and ctrl_mux_sel_o=1, then run; stall_cycles_o=2.
- ex_rd_i=0 matching, or a store with only source1 matching (STORE_FWD=1) → no stall. The same with STORE_FWD=0 → stall.
- FLUSH_DEPTH=3: branch_taken_i for one cycle → if_flush_o=1 for 3 cycles; flush_events_o=1. A second branch in cycle 2 → 3 more cycles from there; flush_events_o=2.
- Branch taken in cycle 1 of a LOAD_LAT=3 stall → stall aborted, flush begins that cycle.
- mem_busy_i held 4 cycles mid-flush (FLUSH_DEPTH=2) → pipe_freeze_o=1 and all enables 0. The flush resumes with its remaining cycle afterwards.
- rst pulse mid-stall → reset output values; counters 0; HZ_RUN after release. Counter preset near 2^CNT_W-1 saturates and does not wrap.
